// File: rtl/spi_slave_phy.sv
// Mode-0 SPI slave PHY: MSB-first chunk deserialiser and serialiser with a single
// transmit holding register. All logic runs on clk; SPI pins are oversampled.
module spi_slave_phy #(
  parameter int                WIDTH       = 8,
  parameter logic [WIDTH-1:0]  TX_IDLE     = '0,
  parameter int                SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sclk,
  input  logic             cs_n,
  input  logic             mosi,
  output logic             miso,
  output logic             miso_oe,
  output logic             rx_dv,
  output logic [WIDTH-1:0] rx_data,
  input  logic             tx_we,
  input  logic [WIDTH-1:0] tx_data,
  output logic             tx_halt
);

  localparam int               CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
  logic                   sclk_dly_q, cs_dly_q;
  logic                   sclk_s, cs_s, mosi_s;

  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0] rx_shift_q, rx_shift_d;
  logic [WIDTH-1:0] rx_data_q, rx_data_d;
  logic             rx_dv_q, rx_dv_d;
  logic [WIDTH-1:0] tx_shift_q, tx_shift_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_full_q, hold_full_d;
  logic             boundary_q, boundary_d;
  logic             miso_q, miso_d;
  logic             tx_we_q;

  logic frame_active, sclk_rise, sclk_fall, cs_fall, cs_rise;
  logic byte_done, tx_load, wr_accept;

  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s   = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  // Synchronisers reset to idle pin levels so no edge is seen coming out of reset
  // while the bus is idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      sclk_dly_q  <= 1'b0;
      cs_dly_q    <= 1'b1;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs_n};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
      sclk_dly_q  <= sclk_s;
      cs_dly_q    <= cs_s;
    end
  end

  assign frame_active = ~cs_s;
  assign sclk_rise    = frame_active &  sclk_s & ~sclk_dly_q;
  assign sclk_fall    = frame_active & ~sclk_s &  sclk_dly_q;
  assign cs_fall      = ~cs_s &  cs_dly_q;
  assign cs_rise      =  cs_s & ~cs_dly_q;
  assign byte_done    = sclk_rise & (bit_cnt_q == LAST_BIT);
  assign tx_load      = cs_fall | byte_done;
  // A load frees the holding register in the same cycle, so a coincident write lands.
  assign wr_accept    = tx_we & ~tx_we_q & (~hold_full_q | tx_load);

  always_comb begin
    // NOTE: every next-state signal gets a default first so no latch is inferred
    // and rx_dv_d falls back to 0, making rx_dv a single-cycle pulse.
    bit_cnt_d   = bit_cnt_q;
    rx_shift_d  = rx_shift_q;
    rx_data_d   = rx_data_q;
    rx_dv_d     = 1'b0;
    tx_shift_d  = tx_shift_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    boundary_d  = boundary_q;
    miso_d      = miso_q;

    if (cs_rise) begin
      bit_cnt_d  = '0;
      rx_shift_d = '0;
      boundary_d = 1'b0;
      miso_d     = 1'b0;
    end else if (sclk_rise) begin
      rx_shift_d = {rx_shift_q[WIDTH-2:0], mosi_s};
      if (byte_done) begin
        rx_data_d = rx_shift_d;
        rx_dv_d   = 1'b1;
        bit_cnt_d = '0;
      end else begin
        bit_cnt_d = bit_cnt_q + 1'b1;
      end
    end

    if (tx_load) begin
      tx_shift_d  = hold_full_q ? hold_q : TX_IDLE;
      hold_full_d = 1'b0;
      if (cs_fall) miso_d = tx_shift_d[WIDTH-1];
      else         boundary_d = 1'b1;
    end else if (sclk_fall) begin
      // The first fall after a byte boundary presents the fresh MSB without shifting.
      if (boundary_q) begin
        miso_d     = tx_shift_q[WIDTH-1];
        boundary_d = 1'b0;
      end else begin
        tx_shift_d = tx_shift_q << 1;
        miso_d     = tx_shift_q[WIDTH-2];
      end
    end

    if (wr_accept) begin
      hold_d      = tx_data;
      hold_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt_q   <= '0;
      rx_shift_q  <= '0;
      rx_data_q   <= '0;
      rx_dv_q     <= 1'b0;
      tx_shift_q  <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      boundary_q  <= 1'b0;
      miso_q      <= 1'b0;
      tx_we_q     <= 1'b0;
    end else begin
      bit_cnt_q   <= bit_cnt_d;
      rx_shift_q  <= rx_shift_d;
      rx_data_q   <= rx_data_d;
      rx_dv_q     <= rx_dv_d;
      tx_shift_q  <= tx_shift_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      boundary_q  <= boundary_d;
      miso_q      <= miso_d;
      tx_we_q     <= tx_we;
    end
  end

  assign miso    = miso_q;
  assign miso_oe = frame_active;
  assign rx_dv   = rx_dv_q;
  assign rx_data = rx_data_q;
  assign tx_halt = hold_full_q;

endmodule

// File: tb/tb_spi_slave_phy.sv
// Directed bench for spi_slave_phy: an SPI master model with 16-clk sclk period,
// an rx_dv monitor, and one task per scenario with hand-computed expectations.
module tb_spi_slave_phy;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sclk = 1'b0;
  logic       cs_n = 1'b1;
  logic       mosi = 1'b0;
  logic       miso, miso_oe, rx_dv, tx_halt;
  logic [7:0] rx_data;
  logic       tx_we = 1'b0;
  logic [7:0] tx_data = '0;

  int total = 0;
  int bad   = 0;
  logic [7:0] rx_q[$];

  spi_slave_phy #(.WIDTH(8), .TX_IDLE(8'h00), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe), .rx_dv(rx_dv), .rx_data(rx_data),
    .tx_we(tx_we), .tx_data(tx_data), .tx_halt(tx_halt)
  );

  always #5 clk = ~clk;

  // Every negedge with rx_dv high logs one chunk, so a stretched pulse shows up as extra entries.
  always @(negedge clk) if (rx_dv) rx_q.push_back(rx_data);

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic write_tx(input logic [7:0] d);
    @(negedge clk);
    tx_data = d;
    tx_we   = 1'b1;
    @(negedge clk);
    tx_we   = 1'b0;
  endtask

  task automatic spi_xfer(input logic [7:0] mo, input int nbits, output logic [7:0] mi);
    mi = '0;
    for (int i = 7; i > 7 - nbits; i--) begin
      mosi = mo[i];
      wait_clks(8);
      sclk = 1'b1;
      mi   = {mi[6:0], miso};
      wait_clks(8);
      sclk = 1'b0;
    end
  endtask

  task automatic cs_low();
    @(negedge clk);
    cs_n = 1'b0;
    wait_clks(8);
  endtask

  task automatic cs_high();
    @(negedge clk);
    cs_n = 1'b1;
    wait_clks(8);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    wait_clks(3);
    total++; if (miso !== 1'b0)    begin bad++; $display("FAIL reset_miso got=%b exp=0", miso); end
    total++; if (miso_oe !== 1'b0) begin bad++; $display("FAIL reset_miso_oe got=%b exp=0", miso_oe); end
    total++; if (rx_dv !== 1'b0)   begin bad++; $display("FAIL reset_rx_dv got=%b exp=0", rx_dv); end
    total++; if (rx_data !== 8'h00) begin bad++; $display("FAIL reset_rx_data got=%h exp=00", rx_data); end
    total++; if (tx_halt !== 1'b0) begin bad++; $display("FAIL reset_tx_halt got=%b exp=0", tx_halt); end
    rst = 1'b0;
    wait_clks(4);
  endtask

  task automatic test_receive();
    logic [7:0] mi;
    rx_q.delete();
    cs_low();
    total++; if (miso_oe !== 1'b1) begin bad++; $display("FAIL rx_miso_oe_in_frame got=%b exp=1", miso_oe); end
    spi_xfer(8'h01, 8, mi);
    spi_xfer(8'hA5, 8, mi);
    cs_high();
    total++; if (rx_q.size() !== 2) begin bad++; $display("FAIL rx_pulse_count got=%0d exp=2", rx_q.size()); end
    if (rx_q.size() >= 2) begin
      total++; if (rx_q[0] !== 8'h01) begin bad++; $display("FAIL rx_byte0 got=%h exp=01", rx_q[0]); end
      total++; if (rx_q[1] !== 8'hA5) begin bad++; $display("FAIL rx_byte1 got=%h exp=a5", rx_q[1]); end
    end
    total++; if (rx_data !== 8'hA5) begin bad++; $display("FAIL rx_hold_after_cs got=%h exp=a5", rx_data); end
    total++; if (miso_oe !== 1'b0)  begin bad++; $display("FAIL rx_miso_oe_after_cs got=%b exp=0", miso_oe); end
  endtask

  task automatic test_transmit();
    logic [7:0] mi;
    write_tx(8'h3C);
    wait_clks(1);
    total++; if (tx_halt !== 1'b1) begin bad++; $display("FAIL tx_halt_after_write got=%b exp=1", tx_halt); end
    cs_low();
    spi_xfer(8'h00, 8, mi);
    total++; if (mi !== 8'h3C)     begin bad++; $display("FAIL tx_byte0 got=%h exp=3c", mi); end
    total++; if (tx_halt !== 1'b0) begin bad++; $display("FAIL tx_halt_after_byte got=%b exp=0", tx_halt); end
    spi_xfer(8'h00, 8, mi);
    total++; if (mi !== 8'h00)     begin bad++; $display("FAIL tx_idle_byte got=%h exp=00", mi); end
    cs_high();
    total++; if (miso !== 1'b0)    begin bad++; $display("FAIL tx_miso_after_cs got=%b exp=0", miso); end
  endtask

  task automatic test_back_pressure();
    logic [7:0] mi;
    write_tx(8'h11);
    write_tx(8'h22);
    wait_clks(1);
    total++; if (tx_halt !== 1'b1) begin bad++; $display("FAIL bp_halt got=%b exp=1", tx_halt); end
    // tx_we held high across the cs_fall load must not refill the register.
    @(negedge clk);
    cs_n    = 1'b0;
    tx_data = 8'h44;
    tx_we   = 1'b1;
    wait_clks(5);
    tx_we   = 1'b0;
    wait_clks(3);
    total++; if (tx_halt !== 1'b0) begin bad++; $display("FAIL bp_held_we_single got=%b exp=0", tx_halt); end
    spi_xfer(8'h00, 8, mi);
    total++; if (mi !== 8'h11)     begin bad++; $display("FAIL bp_byte0 got=%h exp=11", mi); end
    spi_xfer(8'h00, 8, mi);
    total++; if (mi !== 8'h00)     begin bad++; $display("FAIL bp_byte1 got=%h exp=00", mi); end
    cs_high();
  endtask

  task automatic test_back_to_back();
    logic [7:0] got[8];
    write_tx(8'h00);
    fork
      begin
        for (int k = 1; k < 8; k++) begin
          for (int c = 0; c < 500 && tx_halt; c++) @(negedge clk);
          total++; if (tx_halt !== 1'b0) begin bad++; $display("FAIL stream_wait_halt k=%0d got=%b exp=0", k, tx_halt); end
          write_tx(8'(k));
        end
      end
      begin
        cs_low();
        for (int b = 0; b < 8; b++) spi_xfer(8'hFF, 8, got[b]);
        cs_high();
      end
    join
    for (int b = 0; b < 8; b++) begin
      total++; if (got[b] !== 8'(b)) begin bad++; $display("FAIL stream_byte%0d got=%h exp=%h", b, got[b], 8'(b)); end
    end
  endtask

  task automatic test_abort();
    logic [7:0] mi;
    rx_q.delete();
    cs_low();
    spi_xfer(8'hF8, 5, mi);
    cs_high();
    total++; if (rx_q.size() !== 0) begin bad++; $display("FAIL abort_no_dv got=%0d exp=0", rx_q.size()); end
    cs_low();
    spi_xfer(8'h5A, 8, mi);
    cs_high();
    total++; if (rx_q.size() !== 1) begin bad++; $display("FAIL abort_next_count got=%0d exp=1", rx_q.size()); end
    total++; if (rx_data !== 8'h5A) begin bad++; $display("FAIL abort_next_byte got=%h exp=5a", rx_data); end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] mi;
    write_tx(8'h77);
    write_tx(8'h66);
    cs_low();
    spi_xfer(8'hE0, 3, mi);
    @(negedge clk);
    rst  = 1'b1;
    cs_n = 1'b1;
    sclk = 1'b0;
    @(negedge clk);
    total++; if (tx_halt !== 1'b0)  begin bad++; $display("FAIL rstmid_tx_halt got=%b exp=0", tx_halt); end
    total++; if (rx_dv !== 1'b0)    begin bad++; $display("FAIL rstmid_rx_dv got=%b exp=0", rx_dv); end
    total++; if (miso_oe !== 1'b0)  begin bad++; $display("FAIL rstmid_miso_oe got=%b exp=0", miso_oe); end
    total++; if (rx_data !== 8'h00) begin bad++; $display("FAIL rstmid_rx_data got=%h exp=00", rx_data); end
    @(negedge clk);
    rst = 1'b0;
    wait_clks(4);
    rx_q.delete();
    write_tx(8'h96);
    cs_low();
    spi_xfer(8'hC3, 8, mi);
    spi_xfer(8'h00, 8, mi);
    cs_high();
    total++; if (rx_q.size() !== 2) begin bad++; $display("FAIL rstmid_rx_count got=%0d exp=2", rx_q.size()); end
    if (rx_q.size() >= 1) begin
      total++; if (rx_q[0] !== 8'hC3) begin bad++; $display("FAIL rstmid_rx_byte got=%h exp=c3", rx_q[0]); end
    end
    total++; if (mi !== 8'h00) begin bad++; $display("FAIL rstmid_second_tx got=%h exp=00", mi); end
  endtask

  task automatic test_reset_midframe_tx();
    logic [7:0] mi;
    write_tx(8'h96);
    cs_low();
    spi_xfer(8'h00, 8, mi);
    cs_high();
    total++; if (mi !== 8'h96) begin bad++; $display("FAIL rstmid_tx_byte got=%h exp=96", mi); end
  endtask

  initial begin
    test_reset();
    test_receive();
    test_transmit();
    test_back_pressure();
    test_back_to_back();
    test_abort();
    test_reset_midframe();
    test_reset_midframe_tx();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
